alu_operand_fetch: RTL and testbench
====================================

// Module: alu_operand_fetch
// PURPOSE
//  Operand-fetch/issue stage directly upstream of the 64-bit combinational ALU (5-bit op).
//  Holds the register file, reads rs1/rs2 (or selects an immediate for b) and tracks RAW/WAW
//  hazards with a per-register busy scoreboard. Presents one registered {op,a,b,rd} per
//  accepted request on a valid/ready port. The ALU result returns on the writeback port.
// PARAMETERS
//  XLEN   64  datapath width; equals the ALU operand width
//  NREGS  32  architectural registers; register 0 reads as zero
//  OPW    5   ALU opcode width
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  in_valid    in   1          request valid
//  in_ready    out  1          request accepted when in_valid && in_ready
//  in_op       in   OPW        ALU opcode, passed through unchanged
//  in_rs1      in   log2 NREGS source register for a
//  in_rs2      in   log2 NREGS source register for b (ignored when in_use_imm)
//  in_rd       in   log2 NREGS destination register
//  in_use_imm  in   1          1: b = in_imm; 0: b = reg[in_rs2]
//  in_imm      in   XLEN       immediate operand
//  out_valid   out  1          ALU operands valid
//  out_ready   in   1          consumer accepts when out_valid && out_ready
//  out_op      out  OPW        registered opcode
//  out_a       out  XLEN       registered operand a
//  out_b       out  XLEN       registered operand b
//  out_rd      out  log2 NREGS registered destination
//  wb_en       in   1          writeback strobe
//  wb_rd       in   log2 NREGS writeback register
//  wb_data     in   XLEN       writeback value (ALU result)
// BEHAVIOUR
//  - Reset: out_valid=0; out_op/out_a/out_b/out_rd=0; busy[]=0; all registers=0. Stats=0 if built.
//  - Latency: 1 cycle from accept to out_valid. One output slot, no internal queue.
//  - hazard = busy[rs1] | (!use_imm & busy[rs2]) | busy[rd]. Register 0 is never busy.
//  - A busy source is not a hazard when wb_en && wb_rd==that source in the same cycle.
//    In that case wb_data is forwarded into out_a/out_b.
//  - in_ready = (!out_valid | out_ready) & !hazard.
//  - in_ready may depend on the in_* payload but never on in_valid.
//  - Upstream holds the payload stable while in_valid && !in_ready.
//  - Accept: out_* load; out_valid=1. busy[in_rd] set if in_rd != 0.
//  - out_valid && !out_ready: out_* hold bit-stable. A later wb does NOT refresh held operands.
//  - out fire with no accept: out_valid -> 0.
//  - wb_en: reg[wb_rd] <= wb_data and busy[wb_rd] cleared. Writes to register 0 are discarded.
//  - Same cycle clear of busy[r] by wb and set of busy[r] by accept: set wins.
//  - Read-during-write to the same register returns wb_data (write-first bypass).
//  - rst_n low mid-stall clears all state immediately. In-flight writebacks are lost.
// CONFIGURATION
//  - Macro ALU_OPF_STATS_EN defined: adds out ports stat_issued[31:0] and stat_stalls[31:0].
//    stat_issued counts accepts. stat_stalls counts cycles with in_valid && !in_ready.
//    Both saturate at 32'hFFFF_FFFF.
//  - Macro undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package alu_pkg holds: XLEN, OPW, REGW=$clog2(NREGS).
//  - alu_pkg also holds localparam opcode names: ALU_ADD=5'b00000 ... ALU_BEQ=5'b11111.
//  - alu_pkg typedefs: alu_req_t {op,rs1,rs2,rd,use_imm,imm} and alu_issue_t {op,a,b,rd}.
//  - Sub-module alu_regfile: NREGS x XLEN, 2 async read ports, 1 write port.
//    alu_regfile implements the zero register and write-first bypass.
//  - Scoreboard, hazard logic and output register live in alu_operand_fetch.
// TESTING
//  1. Reset; send op=00000 rs1=0 use_imm=1 imm=5 rd=1.
//     -> next cycle out_valid=1, a=0, b=5, out_rd=1. A rs1=1 request is then stalled.
//  2. rd=1 outstanding, request rs1=1 held. Pulse wb_en rd=1 data=7.
//     -> accepted that cycle; out_a=7 next cycle; busy[1]=0 after.
//  3. out_ready=0 for 3 cycles with a pending request.
//     -> out_* unchanged, in_ready=0. Raise out_ready -> accepted the same cycle.
//  4. wb_en rd=0 data=64'hFF, then read rs1=0 -> out_a=0.
//     Request rd=2 while busy[2]=1 -> in_ready=0 until wb rd=2.
//  5. Assert rst_n=0 during a stall.
//     -> out_valid=0 asynchronously; after release, rs1=1 reads 0 and is not stalled.
//  6. With ALU_OPF_STATS_EN: 4 accepts and 3 stall cycles -> stat_issued=4, stat_stalls=3.

Source files
------------

// File: rtl/alu_pkg.sv
// +------------------------------------------------------------------+
// | alu_pkg: shared widths, opcode names and bundles for ALU issue.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int OPW   = 5;
   localparam int REGW  = $clog2(NREGS);

   localparam logic [OPW-1:0] ALU_ADD  = 5'b00000;
   localparam logic [OPW-1:0] ALU_SUB  = 5'b00001;
   localparam logic [OPW-1:0] ALU_AND  = 5'b00010;
   localparam logic [OPW-1:0] ALU_OR   = 5'b00011;
   localparam logic [OPW-1:0] ALU_XOR  = 5'b00100;
   localparam logic [OPW-1:0] ALU_SLL  = 5'b00101;
   localparam logic [OPW-1:0] ALU_SRL  = 5'b00110;
   localparam logic [OPW-1:0] ALU_SRA  = 5'b00111;
   localparam logic [OPW-1:0] ALU_SLT  = 5'b01000;
   localparam logic [OPW-1:0] ALU_SLTU = 5'b01001;
   localparam logic [OPW-1:0] ALU_BEQ  = 5'b11111;

   typedef struct packed {
      logic [OPW-1:0]  op;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
      logic            use_imm;
      logic [XLEN-1:0] imm;
   } alu_req_t;

   typedef struct packed {
      logic [OPW-1:0]  op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [REGW-1:0] rd;
   } alu_issue_t;

   // One-hot register mask; register 0 never appears so it can never be busy.
   function automatic logic [NREGS-1:0] reg_mask(input logic [REGW-1:0] r);
      logic [NREGS-1:0] m;
      m = '0;
      if (r != '0) m[r] = 1'b1;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// +------------------------------------------------------------------+
// | alu_regfile: zero-register file, 2 async reads, 1 write, with    |
// | write-first bypass. Revision: 1.0                                |
// +------------------------------------------------------------------+
`default_nettype none

module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W   = XLEN,
   parameter int NUM_REGS = NREGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      if (rd_addr_a == '0) rd_data_a = '0;
      rd_data_b = regs_q[rd_addr_b];
      if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      if (rd_addr_b == '0) rd_data_b = '0;
   end

endmodule

`default_nettype wire

// File: rtl/alu_operand_fetch.sv
// +------------------------------------------------------------------+
// | alu_operand_fetch: register read, busy scoreboard and one-slot   |
// | issue register for the ALU. Option: ALU_OPF_STATS_EN adds        |
// | stat_issued/stat_stalls counters. Revision: 1.0                  |
// +------------------------------------------------------------------+
`default_nettype none

module alu_operand_fetch
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [REGW-1:0] in_rd,
   input  logic            in_use_imm,
   input  logic [XLEN-1:0] in_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OPW-1:0]  out_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [REGW-1:0] out_rd,
`ifdef ALU_OPF_STATS_EN
   output logic [31:0]     stat_issued,
   output logic [31:0]     stat_stalls,
`endif
   input  logic            wb_en,
   input  logic [REGW-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data
);

   alu_req_t         w_req;
   logic [XLEN-1:0]  w_rf_a;
   logic [XLEN-1:0]  w_rf_b;
   logic             w_src1_busy;
   logic             w_src2_busy;
   logic             w_hazard;
   logic             w_accept;

   logic [NREGS-1:0] busy_q, busy_d;
   logic             out_valid_q, out_valid_d;
   alu_issue_t       issue_q, issue_d;

   assign w_req = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                    use_imm: in_use_imm, imm: in_imm};

   // The regfile bypass already delivers wb_data for a same-cycle writeback.
   alu_regfile u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (w_req.rs1),
      .rd_data_a (w_rf_a),
      .rd_addr_b (w_req.rs2),
      .rd_data_b (w_rf_b),
      .wr_en     (wb_en),
      .wr_addr   (wb_rd),
      .wr_data   (wb_data)
   );

   always_comb begin
      w_src1_busy = busy_q[w_req.rs1] && !(wb_en && (wb_rd == w_req.rs1));
      w_src2_busy = !w_req.use_imm && busy_q[w_req.rs2]
                    && !(wb_en && (wb_rd == w_req.rs2));
      w_hazard    = w_src1_busy || w_src2_busy || busy_q[w_req.rd];
      in_ready    = (!out_valid_q || out_ready) && !w_hazard;
      w_accept    = in_valid && in_ready;
   end

   always_comb begin
      issue_d     = issue_q;
      out_valid_d = out_valid_q && !out_ready;
      if (w_accept) begin
         issue_d.op  = w_req.op;
         issue_d.a   = w_rf_a;
         issue_d.b   = w_req.use_imm ? w_req.imm : w_rf_b;
         issue_d.rd  = w_req.rd;
         out_valid_d = 1'b1;
      end
   end

   // Clear before set so an accept to the register being written back stays busy.
   always_comb begin
      busy_d = busy_q;
      if (wb_en)    busy_d = busy_d & ~reg_mask(wb_rd);
      if (w_accept) busy_d = busy_d | reg_mask(w_req.rd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         issue_q     <= '0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         issue_q     <= issue_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_op    = issue_q.op;
   assign out_a     = issue_q.a;
   assign out_b     = issue_q.b;
   assign out_rd    = issue_q.rd;

`ifdef ALU_OPF_STATS_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] stalls_q, stalls_d;

   always_comb begin
      issued_d = issued_q;
      stalls_d = stalls_q;
      if (w_accept && (issued_q != 32'hFFFF_FFFF)) issued_d = issued_q + 32'd1;
      if (in_valid && !in_ready && (stalls_q != 32'hFFFF_FFFF)) stalls_d = stalls_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q <= '0;
         stalls_q <= '0;
      end else begin
         issued_q <= issued_d;
         stalls_q <= stalls_d;
      end
   end

   assign stat_issued = issued_q;
   assign stat_stalls = stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_fetch.sv
// +------------------------------------------------------------------+
// | tb_alu_operand_fetch: scoreboard bench with an architectural     |
// | model of registers and outstanding destinations. Revision: 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu_operand_fetch;
   import alu_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [OPW-1:0]  in_op = '0;
   logic [REGW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic            in_use_imm = 1'b0;
   logic [XLEN-1:0] in_imm = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [OPW-1:0]  out_op;
   logic [XLEN-1:0] out_a, out_b;
   logic [REGW-1:0] out_rd;
   logic            wb_en = 1'b0;
   logic [REGW-1:0] wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
`ifdef ALU_OPF_STATS_EN
   logic [31:0]     stat_issued, stat_stalls;
`endif

   alu_operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_use_imm(in_use_imm), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd),
`ifdef ALU_OPF_STATS_EN
      .stat_issued(stat_issued), .stat_stalls(stat_stalls),
`endif
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural model: register values plus the list of destinations still awaiting writeback.
   logic [63:0] m_regs [32];
   int          inflight [$];
   alu_issue_t  exp_q [$];
   bit          m_ov;
   int          m_issued, m_stalls;

   function automatic bit pending(input int r);
      if (r == 0) return 1'b0;
      foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] m_read(input int r, input bit we, input int wr,
                                          input logic [63:0] wd);
      if (r == 0) return 64'd0;
      if (we && wr == r) return wd;
      return m_regs[r];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      inflight.delete();
      exp_q.delete();
      m_ov = 1'b0;
      m_issued = 0;
      m_stalls = 0;
   endtask

   task automatic step(input bit v, input logic [4:0] op, input int rs1, input int rs2,
                       input int rd, input bit ui, input logic [63:0] imm, input bit ordy,
                       input bit we, input int wr, input logic [63:0] wd, output bit acc);
      bit src1_wait, src2_wait, exp_rdy;
      alu_issue_t e;
      @(posedge clk);
      #2;
      in_valid = v; in_op = op; in_rs1 = REGW'(rs1); in_rs2 = REGW'(rs2); in_rd = REGW'(rd);
      in_use_imm = ui; in_imm = imm; out_ready = ordy;
      wb_en = we; wb_rd = REGW'(wr); wb_data = wd;
      #6;
      src1_wait = pending(rs1) && !(we && wr == rs1);
      src2_wait = !ui && pending(rs2) && !(we && wr == rs2);
      exp_rdy   = (!m_ov || ordy) && !(src1_wait || src2_wait || pending(rd));
      chk("in_ready", in_ready, exp_rdy);
      acc = v && exp_rdy;
      if (v && !exp_rdy && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (acc) begin
         e.op = op;
         e.a  = m_read(rs1, we, wr, wd);
         e.b  = ui ? imm : m_read(rs2, we, wr, wd);
         e.rd = REGW'(rd);
         exp_q.push_back(e);
         if (m_issued != 32'hFFFF_FFFF) m_issued++;
      end
      if (we) begin
         if (wr != 0) m_regs[wr] = wd;
         for (int i = 0; i < inflight.size(); i++)
            if (inflight[i] == wr) begin inflight.delete(i); break; end
      end
      if (acc && rd != 0) inflight.push_back(rd);
      m_ov = acc || (m_ov && !ordy);
   endtask

   // Monitor: compares each consumed output against the oldest expected issue.
   initial begin
      alu_issue_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_op", out_op, e.op);
               chk("out_a", out_a, e.a);
               chk("out_b", out_b, e.b);
               chk("out_rd", out_rd, e.rd);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc, pv, pacc, v, ui, ordy, we;
      logic [4:0] op;
      logic [63:0] imm, wd;
      int rs1, rs2, rd, wr;
      m_reset();
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_op", out_op, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #2 rst_n = 1'b1;

      // Issue with immediate, then a dependent read of r1 stalls.
      step(1, ALU_ADD, 0, 0, 1, 1, 64'd5, 0, 0, 0, 0, acc); chk("t1_accept", acc, 1);
      step(1, ALU_SUB, 1, 0, 3, 1, 64'd0, 1, 0, 0, 0, acc); chk("t1_stall", acc, 0);
      // Writeback of r1 in the same cycle releases and forwards.
      step(1, ALU_SUB, 1, 0, 3, 1, 64'd0, 1, 1, 1, 64'd7, acc); chk("t2_fwd_accept", acc, 1);
      // Output held; a later writeback to r1 must not refresh it.
      step(1, ALU_OR, 0, 0, 4, 1, 64'd9, 0, 1, 1, 64'd99, acc); chk("t3_hold0", acc, 0);
      step(1, ALU_OR, 0, 0, 4, 1, 64'd9, 0, 0, 0, 0, acc);       chk("t3_hold1", acc, 0);
      step(1, ALU_OR, 0, 0, 4, 1, 64'd9, 0, 0, 0, 0, acc);       chk("t3_hold2", acc, 0);
      step(1, ALU_OR, 0, 0, 4, 1, 64'd9, 1, 0, 0, 0, acc);       chk("t3_release", acc, 1);
      // Writes to r0 are discarded.
      step(0, ALU_ADD, 0, 0, 0, 0, 64'd0, 1, 1, 0, 64'hFF, acc);
      step(1, ALU_AND, 0, 0, 5, 0, 64'd0, 1, 0, 0, 0, acc);      chk("t4_r0_accept", acc, 1);
      step(1, ALU_XOR, 0, 0, 2, 1, 64'd1, 1, 0, 0, 0, acc);      chk("t4_rd2_first", acc, 1);
      step(1, ALU_XOR, 0, 0, 2, 1, 64'd2, 1, 0, 0, 0, acc);      chk("t4_waw_stall", acc, 0);
      step(1, ALU_XOR, 0, 0, 2, 1, 64'd2, 1, 1, 2, 64'h22, acc);
      step(1, ALU_XOR, 0, 0, 2, 1, 64'd2, 0, 0, 0, 0, acc);      chk("t4_waw_release", acc, 1);
      // Asynchronous reset in the middle of a stall.
      step(1, ALU_SLT, 4, 0, 6, 1, 64'd0, 0, 0, 0, 0, acc);      chk("t5_stall", acc, 0);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t5_async_out_valid", out_valid, 0);
      chk("t5_async_out_a", out_a, 0);
      m_reset();
      @(posedge clk); #2 in_valid = 1'b0; rst_n = 1'b1;
      step(1, ALU_ADD, 1, 0, 7, 1, 64'd3, 1, 0, 0, 0, acc);      chk("t5_after_reset", acc, 1);

      // Randomized traffic; upstream holds the payload while stalled.
      pv = 0; pacc = 0;
      v = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0; ui = 0; imm = 0;
      for (int n = 0; n < 600; n++) begin
         if (!(pv && !pacc)) begin
            v = ($urandom_range(0, 3) != 0);
            op = 5'($urandom);
            rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            ui = $urandom_range(0, 1);
            imm = {$urandom, $urandom};
         end
         ordy = ($urandom_range(0, 3) != 0);
         we = 0; wr = 0; wd = {$urandom, $urandom};
         if (inflight.size() != 0 && $urandom_range(0, 2) == 0) begin
            we = 1; wr = inflight[$urandom_range(0, inflight.size() - 1)];
         end else if ($urandom_range(0, 9) == 0) begin
            we = 1; wr = $urandom_range(0, 7);
         end
         step(v, op, rs1, rs2, rd, ui, imm, ordy, we, wr, wd, acc);
         pv = v; pacc = acc;
      end
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
`ifdef ALU_OPF_STATS_EN
      @(negedge clk);
      chk("stat_issued", stat_issued, m_issued);
      chk("stat_stalls", stat_stalls, m_stalls);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
